// File: rtl/uart_rx_mf_if.sv
// Consumer-side view of the uart_rx_mf receive FIFO: head word, per-word flags and pop handshake.
interface uart_rx_mf_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  logic [7:0]                  rx_data;
  logic                        rx_perr;
  logic                        rx_ferr;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_valid, fifo_count,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_valid, fifo_count,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_mf.sv
// Oversampling UART receiver with majority-vote input filter, configurable framing,
// first-word-fall-through receive FIFO and sticky error/break status.
module uart_rx_mf #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         baud_clock,
  input  logic         rx,
  input  logic [1:0]   data_bits,
  input  logic         parity_en,
  input  logic         odd_n_even,
  input  logic         two_stop,
  input  logic         clear_status,
  output logic         overflow,
  output logic         parity_err,
  output logic         framing_error,
  output logic         break_det,
  uart_rx_mf_if.master rx_if
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q;
  logic [2:0]       samp_q;
  logic [TickW-1:0] tick_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             stop_idx_q;
  logic             ferr_q;
  logic             wait_high_q;
  logic [1:0]       cfg_bits_q;
  logic             cfg_par_q;
  logic             cfg_odd_q;
  logic             cfg_two_q;
  logic             push_q;
  logic [7:0]       push_data_q;
  logic             push_perr_q;
  logic             push_ferr_q;
  logic             brk_q;

  logic rx_filt;
  logic last_bit;
  logic perr_calc;
  logic brk_cond;

  assign rx_filt   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign last_bit  = (bit_q == 3'd4 + {1'b0, cfg_bits_q});
  assign perr_calc = cfg_par_q & ((^shift_q ^ par_q) != cfg_odd_q);
  assign brk_cond  = (shift_q == '0) && (!cfg_par_q || !par_q) && !rx_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      samp_q      <= 3'b111;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      stop_idx_q  <= 1'b0;
      ferr_q      <= 1'b0;
      wait_high_q <= 1'b0;
      cfg_bits_q  <= '0;
      cfg_par_q   <= 1'b0;
      cfg_odd_q   <= 1'b0;
      cfg_two_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_perr_q <= 1'b0;
      push_ferr_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      brk_q  <= 1'b0;
      if (baud_clock) begin
        samp_q <= {samp_q[1:0], rx};
        unique case (state_q)
          StIdle: begin
            if (wait_high_q) begin
              if (rx_filt) wait_high_q <= 1'b0;
            end else if (!rx_filt) begin
              state_q    <= StStart;
              tick_q     <= '0;
              bit_q      <= '0;
              shift_q    <= '0;
              par_q      <= 1'b0;
              stop_idx_q <= 1'b0;
              ferr_q     <= 1'b0;
              cfg_bits_q <= data_bits;
              cfg_par_q  <= parity_en;
              cfg_odd_q  <= odd_n_even;
              cfg_two_q  <= two_stop;
            end
          end
          StStart: begin
            if (tick_q == TickMid) begin
              tick_q  <= '0;
              state_q <= rx_filt ? StIdle : StData;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StData: begin
            if (tick_q == TickLast) begin
              tick_q         <= '0;
              shift_q[bit_q] <= rx_filt;
              bit_q          <= bit_q + 3'd1;
              if (last_bit) state_q <= cfg_par_q ? StParity : StStop;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StParity: begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              par_q   <= rx_filt;
              state_q <= StStop;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          StStop: begin
            if (tick_q == TickLast) begin
              tick_q <= '0;
              // A break is decided on the first stop bit regardless of stop-bit count.
              if (!stop_idx_q && brk_cond) begin
                brk_q       <= 1'b1;
                wait_high_q <= 1'b1;
                state_q     <= StIdle;
              end else if (!stop_idx_q && cfg_two_q) begin
                ferr_q     <= !rx_filt;
                stop_idx_q <= 1'b1;
              end else begin
                push_q      <= 1'b1;
                push_data_q <= shift_q;
                push_perr_q <= perr_calc;
                push_ferr_q <= ferr_q | !rx_filt;
                state_q     <= StIdle;
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [9:0]       head;

  assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
  assign do_pop    = (count_q != '0) && rx_if.rx_ready;
  assign do_push   = push_q && (!fifo_full || do_pop);
  assign drop      = push_q && fifo_full && !do_pop;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_ferr_q, push_perr_q, push_data_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  logic ovf_q, perr_flag_q, ferr_flag_q, brk_flag_q;

  // Set events are applied after the clear so that a coincident set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      brk_flag_q  <= 1'b0;
    end else begin
      if (clear_status) begin
        ovf_q       <= 1'b0;
        perr_flag_q <= 1'b0;
        ferr_flag_q <= 1'b0;
        brk_flag_q  <= 1'b0;
      end
      if (drop)                  ovf_q       <= 1'b1;
      if (push_q && push_perr_q) perr_flag_q <= 1'b1;
      if (push_q && push_ferr_q) ferr_flag_q <= 1'b1;
      if (brk_q)                 brk_flag_q  <= 1'b1;
    end
  end

  assign rx_if.rx_valid   = !reset && (count_q != '0);
  assign rx_if.fifo_count = reset ? '0 : count_q;
  assign rx_if.rx_data    = rx_if.rx_valid ? head[7:0] : '0;
  assign rx_if.rx_perr    = rx_if.rx_valid & head[8];
  assign rx_if.rx_ferr    = rx_if.rx_valid & head[9];
  assign overflow         = !reset & ovf_q;
  assign parity_err       = !reset & perr_flag_q;
  assign framing_error    = !reset & ferr_flag_q;
  assign break_det        = !reset & brk_flag_q;

endmodule

// File: tb/tb_uart_rx_mf.sv
// Bench for uart_rx_mf: directed frames plus randomized frames against a queue-based
// reference model of the receive FIFO and sticky status.
module tb_uart_rx_mf;
  localparam int unsigned Os      = 16;
  localparam int unsigned Depth   = 4;
  localparam int unsigned BaudDiv = 2;
  localparam int unsigned BitClk  = Os * BaudDiv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] data_bits = 2'b11;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       two_stop = 1'b0;
  logic       clear_status = 1'b0;
  logic       overflow, parity_err, framing_error, break_det;

  uart_rx_mf_if #(.FIFO_DEPTH(Depth)) rx_if ();

  uart_rx_mf #(.OVERSAMPLE(Os), .FIFO_DEPTH(Depth)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_clock    (baud_clock),
    .rx            (rx),
    .data_bits     (data_bits),
    .parity_en     (parity_en),
    .odd_n_even    (odd_n_even),
    .two_stop      (two_stop),
    .clear_status  (clear_status),
    .overflow      (overflow),
    .parity_err    (parity_err),
    .framing_error (framing_error),
    .break_det     (break_det),
    .rx_if         (rx_if)
  );

  always #5 clk = ~clk;

  int unsigned baud_div_cnt = 0;
  initial forever begin
    @(negedge clk);
    baud_div_cnt = (baud_div_cnt + 1) % BaudDiv;
    baud_clock   = (baud_div_cnt == 0);
  end

  // Reference model: received words as {ferr, perr, data} plus sticky flags.
  logic [9:0] m_q[$];
  logic       m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_brk = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BitClk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic [1:0] bits, input logic pen,
                            input logic odd, input logic two, input logic flip,
                            input logic stop1, input logic stop2);
    int         nb;
    logic [7:0] w;
    logic       pbit;
    logic       perr;
    logic       ferr;
    nb   = 5 + int'(bits);
    w    = data & 8'((1 << nb) - 1);
    pbit = odd ^ (^w) ^ flip;
    data_bits  = bits;
    parity_en  = pen;
    odd_n_even = odd;
    two_stop   = two;
    hold_bit(1'b0);
    // Scramble configuration mid-frame; the frame in flight must ignore it.
    data_bits  = 2'($urandom);
    parity_en  = 1'($urandom);
    odd_n_even = 1'($urandom);
    two_stop   = 1'($urandom);
    for (int i = 0; i < nb; i++) hold_bit(w[i]);
    if (pen) hold_bit(pbit);
    hold_bit(stop1);
    if (two) hold_bit(stop2);
    rx = 1'b1;
    if (w == 8'h00 && (!pen || !pbit) && !stop1) begin
      m_brk = 1'b1;
    end else begin
      perr = pen & flip;
      ferr = !stop1 || (two && !stop2);
      if (perr) m_perr = 1'b1;
      if (ferr) m_ferr = 1'b1;
      if (m_q.size() < Depth) m_q.push_back({ferr, perr, w});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_state();
    check("fifo_count", 32'(rx_if.fifo_count), 32'(m_q.size()));
    check("rx_valid", 32'(rx_if.rx_valid), 32'(m_q.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("parity_err", 32'(parity_err), 32'(m_perr));
    check("framing_error", 32'(framing_error), 32'(m_ferr));
    check("break_det", 32'(break_det), 32'(m_brk));
  endtask

  task automatic pop_one();
    logic [9:0] e;
    if (m_q.size() == 0) begin
      check("empty_valid", 32'(rx_if.rx_valid), 32'd0);
    end else begin
      e = m_q.pop_front();
      check("head_valid", 32'(rx_if.rx_valid), 32'd1);
      check("head_data", 32'(rx_if.rx_data), 32'(e[7:0]));
      check("head_perr", 32'(rx_if.rx_perr), 32'(e[8]));
      check("head_ferr", 32'(rx_if.rx_ferr), 32'(e[9]));
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
    end
  endtask

  task automatic clear_flags();
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_count", 32'(rx_if.fifo_count), 32'd0);
    check("rst_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_perr", 32'(rx_if.rx_perr), 32'd0);
    check("rst_ferr", 32'(rx_if.rx_ferr), 32'd0);
    check("rst_flags", 32'({overflow, parity_err, framing_error, break_det}), 32'd0);
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    idle_bits(2);
    check_state();

    // 8N1 0xA5
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check("a5_count", 32'(rx_if.fifo_count), 32'd1);
    check_state();
    pop_one();

    // 7E1 0x41 with wrong parity, then clear
    send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    check("p41_flag", 32'(parity_err), 32'd1);
    check_state();
    pop_one();
    clear_flags();
    check("p41_clear", 32'(parity_err), 32'd0);

    // Quarter-bit glitch, then 0x3C
    rx = 1'b0;
    repeat (Os / 4 * BaudDiv) @(negedge clk);
    idle_bits(2);
    check_state();
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check_state();
    pop_one();

    // Overflow: five words into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle_bits(1);
    end
    check("ovf_count", 32'(rx_if.fifo_count), 32'(Depth));
    check_state();
    for (int i = 0; i < 4; i++) pop_one();
    check_state();
    clear_flags();

    // 8N2 with bad second stop, then a long break
    send_frame(8'($urandom), 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check_state();
    pop_one();
    clear_flags();
    rx = 1'b0;
    repeat (12 * BitClk) @(negedge clk);
    m_brk = 1'b1;
    check_state();
    idle_bits(12);
    check_state();
    clear_flags();
    send_frame(8'h99, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check_state();
    pop_one();

    // Reset during data bit 3 with a word queued and a flag set
    send_frame(8'h6B, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    check_state();
    data_bits = 2'b11; parity_en = 1'b0; two_stop = 1'b0;
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b1);
    rx = 1'b0;
    repeat (BitClk / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    m_q.delete();
    m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0;
    idle_bits(3);
    check_state();
    send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check_state();
    pop_one();

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       s1;
      int         np;
      d  = 8'($urandom);
      s1 = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        d  = 8'h00;
        s1 = 1'b0;
      end
      send_frame(d, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), s1, ($urandom_range(0, 7) != 0));
      idle_bits(1 + int'($urandom_range(0, 1)));
      check_state();
      np = int'($urandom_range(0, 2));
      for (int j = 0; j < np; j++) pop_one();
      if ($urandom_range(0, 4) == 0) clear_flags();
    end
    while (m_q.size() != 0) pop_one();
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
